huffman_encoder: RTL and testbench

Serializing encoder for the 8-symbol truncated-unary prefix code consumed by `huffman_decoder`. Symbols 0–7 enter through a valid/ready port and are buffered in a small FIFO. The encoder emits one code bit per accepted bit-handshake, MSB-first, with no bubbles between back-to-back codewords. It sits at the producer end of the bit link and drives `huffman_decoder`'s `bit_in`/`data_valid` directly in loopback benches.

---
 rtl/huffman_encoder.sv | 115 +++++++++++
 tb/tb_huffman_encoder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_encoder.sv
// Truncated-unary prefix encoder for symbols 0-7: a small symbol FIFO
// feeds a serializer that emits one code bit per bit handshake, MSB-first.
module huffman_encoder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             sym_err,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e           state_q;
    logic [2:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       cur_q, cnt_q, head;
    logic             sym_ready_q, bit_out_q, sym_err_q, busy_q;
    logic             accept, legal, push, pop, last, active_d;

    // Handshake decode, pop decision and next FIFO occupancy.
    always_comb begin
        accept   = sym_valid && sym_ready_q;
        legal    = (sym_in[7:3] == 5'd0);
        push     = accept && legal;
        head     = mem_q[rd_q];
        last     = (cur_q == 3'd7) ? (cnt_q == 3'd6) : (cnt_q == cur_q);
        pop      = (count_q != '0) && ((state_q == IDLE) || (bit_ready && last));
        active_d = (state_q == SHIFT);
        if (pop) begin
            active_d = 1'b1;
        end else if ((state_q == SHIFT) && bit_ready && last) begin
            active_d = 1'b0;
        end
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Symbol storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= sym_in[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            cur_q       <= '0;
            cnt_q       <= '0;
            sym_ready_q <= 1'b0;
            bit_out_q   <= 1'b0;
            sym_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            if (push) begin
                wr_q <= wr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            count_q     <= count_d;
            sym_ready_q <= (count_d < CNT_W'(FIFO_DEPTH));
            sym_err_q   <= accept && !legal;
            busy_q      <= active_d || (count_d != '0);

            // bit_out is registered as (cnt < cur_sym) of the next state.
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        cur_q     <= head;
                        cnt_q     <= '0;
                        bit_out_q <= (head != 3'd0);
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_ready) begin
                        if (!last) begin
                            cnt_q     <= cnt_q + 3'd1;
                            bit_out_q <= (({1'b0, cnt_q} + 4'd1) < {1'b0, cur_q});
                        end else if (pop) begin
                            cur_q     <= head;
                            cnt_q     <= '0;
                            bit_out_q <= (head != 3'd0);
                        end else begin
                            state_q   <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign sym_ready  = sym_ready_q;
    assign bit_out    = bit_out_q;
    assign bit_valid  = (state_q == SHIFT);
    assign sym_err    = sym_err_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed bench for huffman_encoder: codeword streams, backpressure,
// FIFO full, illegal symbols and reset in the middle of a codeword.
module tb_huffman_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;
    logic       bit_out;
    logic       bit_valid;
    logic       bit_ready;
    logic       sym_err;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    logic [63:0] strm;
    int          len;
    int          valid_cycles;
    int          valid_starts;
    logic        prev_v;

    huffman_encoder #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .sym_err    (sym_err),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect every bit actually handed over to the sink.
    always @(negedge clk) begin
        if (rst_n && bit_valid && bit_ready) begin
            strm = {strm[62:0], bit_out};
            len  = len + 1;
        end
        if (bit_valid) valid_cycles = valid_cycles + 1;
        if (bit_valid && !prev_v) valid_starts = valid_starts + 1;
        prev_v = bit_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stream();
        strm         = '0;
        len          = 0;
        valid_cycles = 0;
        valid_starts = 0;
    endtask

    task automatic push_sym(input logic [7:0] s);
        int n;
        n         = 0;
        sym_in    = s;
        sym_valid = 1'b1;
        while (!sym_ready && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL push_timeout sym=%0d sym_ready=%b required 1", s, sym_ready);
        end
        tick();
        sym_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain_timeout busy=%b required 0", busy);
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        sym_in    = '0;
        sym_valid = 1'b0;
        bit_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bit_valid, bit_out, sym_err, busy, fifo_count} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b b=%b e=%b busy=%b cnt=%0d required all 0",
                     bit_valid, bit_out, sym_err, busy, fifo_count);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_sym_ready got %b required 1", sym_ready);
        end
    endtask

    task automatic test_single();
        clear_stream();
        bit_ready = 1'b1;
        push_sym(8'd0);
        checks++;
        if (fifo_count !== 3'd1 || bit_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_accept cnt=%0d v=%b required cnt=1 v=0", fifo_count, bit_valid);
        end
        tick();
        checks++;
        if (bit_valid !== 1'b1 || bit_out !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL single_first_bit v=%b b=%b cnt=%0d required v=1 b=0 cnt=0",
                     bit_valid, bit_out, fifo_count);
        end
        tick();
        checks++;
        if (bit_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done v=%b busy=%b required 0 0", bit_valid, busy);
        end
        checks++;
        if (len !== 1 || strm[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_stream len=%0d bit=%b required len=1 bit=0", len, strm[0]);
        end
    endtask

    task automatic test_sequence();
        logic [18:0] exp;
        exp = {1'b0, 2'b10, 7'b1111111, 3'b110, 6'b111110};
        clear_stream();
        bit_ready = 1'b1;
        push_sym(8'd0);
        push_sym(8'd1);
        push_sym(8'd7);
        push_sym(8'd2);
        push_sym(8'd5);
        drain();
        checks++;
        if (len !== 19 || strm[18:0] !== exp) begin
            errors++;
            $display("FAIL seq_stream len=%0d bits=%b required len=19 bits=%b", len, strm[18:0], exp);
        end
        checks++;
        if (valid_cycles !== 19 || valid_starts !== 1) begin
            errors++;
            $display("FAIL seq_contiguous cycles=%0d runs=%0d required 19 1", valid_cycles, valid_starts);
        end
    endtask

    task automatic test_backpressure();
        clear_stream();
        bit_ready = 1'b1;
        push_sym(8'd3);
        repeat (3) tick();
        bit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bit_valid !== 1'b1 || bit_out !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d v=%b b=%b required 1 1", i, bit_valid, bit_out);
            end
        end
        bit_ready = 1'b1;
        drain();
        checks++;
        if (len !== 4 || strm[3:0] !== 4'b1110) begin
            errors++;
            $display("FAIL bp_stream len=%0d bits=%b required len=4 bits=1110", len, strm[3:0]);
        end
    endtask

    task automatic test_full_fifo();
        logic [26:0] exp;
        int n;
        exp = {2'b10, 3'b110, 4'b1110, 5'b11110, 6'b111110, 7'b1111110};
        clear_stream();
        bit_ready = 1'b0;
        for (int s = 1; s <= 5; s++) push_sym(8'(s));
        checks++;
        if (fifo_count !== 3'd4 || sym_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state cnt=%0d rdy=%b required cnt=4 rdy=0", fifo_count, sym_ready);
        end
        sym_in    = 8'd6;
        sym_valid = 1'b1;
        repeat (3) tick();
        checks++;
        if (fifo_count !== 3'd4 || sym_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_hold cnt=%0d rdy=%b busy=%b required 4 0 1", fifo_count, sym_ready, busy);
        end
        bit_ready = 1'b1;
        n = 0;
        while (!sym_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        sym_valid = 1'b0;
        drain();
        checks++;
        if (len !== 27 || strm[26:0] !== exp) begin
            errors++;
            $display("FAIL full_stream len=%0d bits=%b required len=27 bits=%b", len, strm[26:0], exp);
        end
    endtask

    task automatic test_illegal();
        clear_stream();
        bit_ready = 1'b1;
        push_sym(8'd8);
        checks++;
        if (sym_err !== 1'b1 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL illegal_8 err=%b cnt=%0d required 1 0", sym_err, fifo_count);
        end
        tick();
        checks++;
        if (sym_err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse err=%b required 0", sym_err);
        end
        push_sym(8'd9);
        checks++;
        if (sym_err !== 1'b1 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL illegal_9 err=%b cnt=%0d required 1 0", sym_err, fifo_count);
        end
        push_sym(8'd4);
        checks++;
        if (sym_err !== 1'b0 || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL legal_4 err=%b cnt=%0d required 0 1", sym_err, fifo_count);
        end
        drain();
        checks++;
        if (len !== 5 || strm[4:0] !== 5'b11110) begin
            errors++;
            $display("FAIL illegal_stream len=%0d bits=%b required len=5 bits=11110", len, strm[4:0]);
        end
    endtask

    task automatic test_reset_mid();
        clear_stream();
        bit_ready = 1'b1;
        push_sym(8'd6);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (bit_valid !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset v=%b cnt=%0d busy=%b required 0 0 0", bit_valid, fifo_count, busy);
        end
        checks++;
        if (len !== 3 || strm[2:0] !== 3'b111) begin
            errors++;
            $display("FAIL midreset_partial len=%0d bits=%b required len=3 bits=111", len, strm[2:0]);
        end
        rst_n = 1'b1;
        clear_stream();
        push_sym(8'd1);
        drain();
        checks++;
        if (len !== 2 || strm[1:0] !== 2'b10) begin
            errors++;
            $display("FAIL midreset_after len=%0d bits=%b required len=2 bits=10", len, strm[1:0]);
        end
    endtask

    initial begin
        prev_v = 1'b0;
        clear_stream();
        test_reset();
        test_single();
        test_sequence();
        test_backpressure();
        test_full_fifo();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
